cdb_broadcaster: RTL



---
 rtl/cdb_broadcaster.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cdb_broadcaster.sv
// CDB transmitter: per-FU completion FIFOs, round-robin pick, registered broadcast.
// Optional CDB_CONFLICT_COUNT_EN adds a saturating count of multi-candidate edges.
module cdb_broadcaster #(
  parameter int NUM_FU    = 4,
  parameter int TAG_W     = 5,
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_FU-1:0]       fu_valid,
  input  logic [NUM_FU*TAG_W-1:0] fu_tag,
  input  logic [NUM_FU*XLEN-1:0]  fu_value,
  output logic [NUM_FU-1:0]       fu_ready,
  input  logic                    squash,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [XLEN-1:0]         cdb_value
`ifdef CDB_CONFLICT_COUNT_EN
  ,
  output logic [31:0]             conflict_count
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [TAG_W-1:0] tag_mem_q [NUM_FU][BUF_DEPTH];
  logic [XLEN-1:0]  val_mem_q [NUM_FU][BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_FU];
  logic [PTR_W-1:0] wr_ptr_d [NUM_FU];
  logic [PTR_W-1:0] rd_ptr_q [NUM_FU];
  logic [PTR_W-1:0] rd_ptr_d [NUM_FU];
  logic [CNT_W-1:0] count_q  [NUM_FU];
  logic [CNT_W-1:0] count_d  [NUM_FU];
  logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]  cdb_value_q, cdb_value_d;

  logic [NUM_FU-1:0] push, pop, nonempty;
  logic              found;
  logic [RR_W-1:0]   win;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (32'(p) == BUF_DEPTH - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      nonempty[i] = (count_q[i] != '0);
      fu_ready[i] = (count_q[i] < CNT_W'(BUF_DEPTH));
    end
  end

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_FU.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        win   = RR_W'(idx);
      end
    end
  end

  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_tag_d   = '0;
    cdb_value_d = '0;
    rr_ptr_d    = rr_ptr_q;
    for (int i = 0; i < NUM_FU; i++) begin
      push[i]     = fu_valid[i] && fu_ready[i] &&
                    (fu_tag[i*TAG_W +: TAG_W] != '0) && !squash;
      pop[i]      = found && !squash && (win == RR_W'(i));
      count_d[i]  = count_q[i];
      wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
      if (push[i] && !pop[i])      count_d[i] = count_q[i] + CNT_W'(1);
      else if (pop[i] && !push[i]) count_d[i] = count_q[i] - CNT_W'(1);
    end
    if (squash) begin
      rr_ptr_d = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        count_d[i]  = '0;
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end
    end else if (found) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = tag_mem_q[win][rd_ptr_q[win]];
      cdb_value_d = val_mem_q[win][rd_ptr_q[win]];
      rr_ptr_d    = (32'(win) == NUM_FU - 1) ? '0 : win + RR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        count_q[i]  <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      for (int i = 0; i < NUM_FU; i++) begin
        count_q[i]  <= count_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // Storage needs no reset: occupancy is governed by the counts alone.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        tag_mem_q[i][wr_ptr_q[i]] <= fu_tag[i*TAG_W +: TAG_W];
        val_mem_q[i][wr_ptr_q[i]] <= fu_value[i*XLEN +: XLEN];
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;

`ifdef CDB_CONFLICT_COUNT_EN
  logic [31:0] conflict_q;
  logic        multi;

  assign multi = ((nonempty & (nonempty - NUM_FU'(1))) != '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      conflict_q <= '0;
    end else if (!squash && multi && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  assign conflict_count = conflict_q;
`endif

endmodule
